// File: rtl/gate_interlock_pkg.sv
// Shared definitions for the gate interlock: one-hot leg states, defaults and
// request-vector helpers. Request vectors are always ordered {t, a, b}.
package gate_interlock_pkg;

  localparam int         NUM_SW   = 3;
  localparam int         DT_W_DEF = 8;
  localparam logic [7:0] DT_DEF   = 8'd20;

  typedef enum logic [4:0] {
    S_OFF   = 5'b00001,
    S_T     = 5'b00010,
    S_A     = 5'b00100,
    S_B     = 5'b01000,
    S_FAULT = 5'b10000
  } state_t;

  typedef logic [NUM_SW-1:0] req_t;

  // True when more than one bit is set (clearing the lowest set bit leaves something).
  function automatic logic multi_req(input req_t r);
    return (r & (r - req_t'(1))) != '0;
  endfunction

  function automatic state_t sw_state(input req_t r);
    case (r)
      3'b100:  return S_T;
      3'b010:  return S_A;
      3'b001:  return S_B;
      default: return S_OFF;
    endcase
  endfunction

endpackage

// File: rtl/gate_interlock_dt_counter.sv
// Loadable saturating down-counter timing the all-off dead interval.
// done rises on the cycle the leg may be granted again; a value of 0 acts as 1.
module dt_counter #(
  parameter int DT_W = 8
) (
  input  logic            clk_in,
  input  logic            load,
  input  logic [DT_W-1:0] value,
  output logic            done
);

  logic [DT_W-1:0] cnt;

  // The load cycle itself is the first all-off cycle, hence value-1.
  always_ff @(posedge clk_in) begin
    if (load)
      cnt <= (value == '0) ? '0 : value - 1'b1;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/gate_interlock.sv
// Three-switch leg interlock: one gate at a time, all-off dead time before every
// turn-on, and a sticky fault on persistent overlapping requests.
module gate_interlock
  import gate_interlock_pkg::*;
#(
  parameter int DT_W    = DT_W_DEF,
  parameter int OVL_MAX = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            en,
  input  logic            pwm_t,
  input  logic            pwm_a,
  input  logic            pwm_b,
  input  logic [DT_W-1:0] dead_cyc,
  input  logic            fault_clr,
  output logic            gate_t,
  output logic            gate_a,
  output logic            gate_b,
  output logic            fault,
  output logic [2:0]      fault_src
);

  localparam int OW = $clog2(OVL_MAX + 1);

  state_t        state, state_nx;
  req_t          req;
  logic [OW-1:0] ovl_cnt, ovl_nx;
  logic          multi, trip, own_req, dt_load, dt_done;

  assign req   = {pwm_t, pwm_a, pwm_b};
  assign multi = multi_req(req);
  assign trip  = (state != S_FAULT) && multi && (ovl_cnt == OW'(OVL_MAX - 1));

  always_comb begin
    own_req = 1'b0;
    case (state)
      S_T:     own_req = pwm_t;
      S_A:     own_req = pwm_a;
      S_B:     own_req = pwm_b;
      default: own_req = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    ovl_nx   = '0;
    if (state != S_FAULT && multi)
      ovl_nx = ovl_cnt + 1'b1;
    case (state)
      S_OFF: begin
        if (trip)
          state_nx = S_FAULT;
        else if (dt_done && en && !multi && req != '0)
          state_nx = sw_state(req);
      end
      S_T, S_A, S_B: begin
        if (trip)
          state_nx = S_FAULT;
        else if (!own_req || !en)
          state_nx = S_OFF;
      end
      S_FAULT: begin
        if (fault_clr && req == '0)
          state_nx = S_OFF;
      end
      default: state_nx = S_OFF;
    endcase
    if (trip)
      ovl_nx = '0;
  end

  // Reset arms the dead interval exactly like a gate falling.
  assign dt_load = rst_in || (state_nx == S_OFF && state != S_OFF);

  dt_counter #(.DT_W(DT_W)) u_dt (
    .clk_in (clk_in),
    .load   (dt_load),
    .value  (dead_cyc),
    .done   (dt_done)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_OFF;
      ovl_cnt   <= '0;
      gate_t    <= 1'b0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      fault     <= 1'b0;
      fault_src <= '0;
    end else begin
      state   <= state_nx;
      ovl_cnt <= ovl_nx;
      gate_t  <= (state_nx == S_T);
      gate_a  <= (state_nx == S_A);
      gate_b  <= (state_nx == S_B);
      fault   <= (state_nx == S_FAULT);
      if (trip)
        fault_src <= req;
      else if (state_nx != S_FAULT)
        fault_src <= '0;
    end
  end

endmodule

// File: tb/tb_gate_interlock.sv
// Directed vector table plus randomized PWM streams against a cycle-level model
// built from the leg rules (owner, dead-time low count, overlap run length).
module tb_gate_interlock;
  import gate_interlock_pkg::*;

  localparam int OVL_MAX = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1, en = 1'b1, pwm_t = 1'b0, pwm_a = 1'b0, pwm_b = 1'b0;
  logic       fault_clr = 1'b0;
  logic [7:0] dead_cyc = 8'd4;
  logic       gate_t, gate_a, gate_b, fault;
  logic [2:0] fault_src;

  int checks = 0, failures = 0, cyc = 0;

  gate_interlock #(.DT_W(8), .OVL_MAX(OVL_MAX)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (en),
    .pwm_t     (pwm_t),
    .pwm_a     (pwm_a),
    .pwm_b     (pwm_b),
    .dead_cyc  (dead_cyc),
    .fault_clr (fault_clr),
    .gate_t    (gate_t),
    .gate_a    (gate_a),
    .gate_b    (gate_b),
    .fault     (fault),
    .fault_src (fault_src)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       rst, en, t, a, b, clr;
    logic [7:0] dead;
    logic [2:0] eg;
    logic       ef;
    logic [2:0] es;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int n, input logic rst, en, t, a, b, clr, input logic [7:0] dead,
                     input logic [2:0] eg, input logic ef, input logic [2:0] es);
    vec_t v;
    v.rst = rst; v.en = en; v.t = t; v.a = a; v.b = b; v.clr = clr; v.dead = dead;
    v.eg = eg; v.ef = ef; v.es = es;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: who owns the leg, how many all-low cycles have elapsed
  // since the last fall, the dead time latched at that fall, and the overlap run.
  int         m_own, m_run, m_low, m_d;
  logic       m_flt;
  logic [2:0] m_src;
  logic [2:0] prev_g = 3'b000;
  int         obs_low = 0;

  function automatic int dmax(input logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  function automatic logic [2:0] m_gates();
    logic [2:0] g;
    g = 3'b000;
    if (m_own >= 0) g[m_own] = 1'b1;
    return g;
  endfunction

  task automatic model_step();
    logic [2:0] r;
    int pop;
    r   = {pwm_t, pwm_a, pwm_b};
    pop = $countones(r);
    if (rst_in) begin
      m_own = -1; m_flt = 1'b0; m_src = 3'b000; m_run = 0; m_low = 0; m_d = dmax(dead_cyc);
    end else if (m_flt) begin
      if (fault_clr && r == 3'b000) begin
        m_flt = 1'b0; m_src = 3'b000; m_low = 0; m_d = dmax(dead_cyc);
      end
    end else begin
      m_run = (pop > 1) ? m_run + 1 : 0;
      if (m_run >= OVL_MAX) begin
        m_flt = 1'b1; m_src = r; m_own = -1; m_run = 0;
      end else if (m_own >= 0) begin
        if (!r[m_own] || !en) begin
          m_own = -1; m_low = 0; m_d = dmax(dead_cyc);
        end
      end else begin
        m_low++;
        if (m_low >= m_d && en && pop == 1)
          m_own = r[2] ? 2 : (r[1] ? 1 : 0);
      end
    end
  endtask

  task automatic step();
    logic [2:0] g;
    @(posedge clk_in);
    model_step();
    cyc++;
    #1;
    g = {gate_t, gate_a, gate_b};
    chk("model_gates", g, m_gates());
    chk("model_fault", fault, m_flt);
    chk("model_fault_src", fault_src, m_src);
    chk("gate_onehot", $countones(g) <= 1, 1'b1);
    chk("gate_in_fault", fault && g != 3'b000, 1'b0);
    if (prev_g == 3'b000 && g != 3'b000)
      chk("dead_min", obs_low >= m_d, 1'b1);
    if (prev_g != 3'b000 && g != 3'b000)
      chk("direct_switch", g, prev_g);
    obs_low = (g == 3'b000) ? obs_low + 1 : 0;
    prev_g  = g;
  endtask

  initial begin
    //   n  rst en t  a  b  clr dead  gates   f  src
    // reset with pwm_t held, then D=4 all-off cycles
    add(3, 1, 1, 1, 0, 0, 0, 8'd4, 3'b000, 0, 3'b000);
    add(3, 0, 1, 1, 0, 0, 0, 8'd4, 3'b000, 0, 3'b000);
    add(1, 0, 1, 1, 0, 0, 0, 8'd4, 3'b100, 0, 3'b000);
    // three overlap cycles do not trip, four do
    add(3, 0, 1, 1, 0, 1, 0, 8'd4, 3'b100, 0, 3'b000);
    add(1, 0, 1, 1, 0, 0, 0, 8'd4, 3'b100, 0, 3'b000);
    add(3, 0, 1, 1, 0, 1, 0, 8'd4, 3'b100, 0, 3'b000);
    add(1, 0, 1, 1, 0, 1, 0, 8'd4, 3'b000, 1, 3'b101);
    // reset clears a latched fault
    add(1, 1, 1, 0, 0, 0, 0, 8'd4, 3'b000, 0, 3'b000);
    add(3, 0, 1, 1, 0, 0, 0, 8'd4, 3'b000, 0, 3'b000);
    add(2, 0, 1, 1, 0, 0, 0, 8'd4, 3'b100, 0, 3'b000);
    // t falls as a rises: exactly 4 all-off cycles
    add(4, 0, 1, 0, 1, 0, 0, 8'd4, 3'b000, 0, 3'b000);
    add(2, 0, 1, 0, 1, 0, 0, 8'd0, 3'b010, 0, 3'b000);
    // dead_cyc=0: exactly one all-off cycle
    add(1, 0, 1, 0, 0, 1, 0, 8'd0, 3'b000, 0, 3'b000);
    add(1, 0, 1, 0, 0, 1, 0, 8'd0, 3'b001, 0, 3'b000);
    // en=0 drops gate_b, re-grant after D
    add(1, 0, 0, 0, 0, 1, 0, 8'd4, 3'b000, 0, 3'b000);
    add(3, 0, 1, 0, 0, 1, 0, 8'd4, 3'b000, 0, 3'b000);
    add(1, 0, 1, 0, 0, 1, 0, 8'd4, 3'b001, 0, 3'b000);
    // fault, clear ignored while a request is active, then honoured
    add(3, 0, 1, 0, 1, 1, 0, 8'd4, 3'b001, 0, 3'b000);
    add(1, 0, 1, 0, 1, 1, 0, 8'd4, 3'b000, 1, 3'b011);
    add(1, 0, 1, 0, 1, 0, 1, 8'd4, 3'b000, 1, 3'b011);
    add(1, 0, 1, 0, 0, 0, 1, 8'd4, 3'b000, 0, 3'b000);
    add(3, 0, 1, 0, 1, 0, 0, 8'd4, 3'b000, 0, 3'b000);
    add(1, 0, 1, 0, 1, 0, 0, 8'd4, 3'b010, 0, 3'b000);
    // overlap in S_OFF keeps the leg off and trips even with en=0
    add(1, 0, 1, 0, 0, 0, 0, 8'd4, 3'b000, 0, 3'b000);
    add(2, 0, 1, 1, 1, 0, 0, 8'd4, 3'b000, 0, 3'b000);
    add(1, 0, 0, 1, 1, 0, 0, 8'd4, 3'b000, 0, 3'b000);
    add(1, 0, 0, 1, 1, 0, 0, 8'd4, 3'b000, 1, 3'b110);
    add(1, 0, 0, 0, 0, 0, 0, 8'd4, 3'b000, 1, 3'b110);
    add(1, 0, 0, 0, 0, 0, 1, 8'd2, 3'b000, 0, 3'b000);
    // D=2 after clear, then reset mid-pulse
    add(1, 0, 1, 1, 0, 0, 0, 8'd2, 3'b000, 0, 3'b000);
    add(1, 0, 1, 1, 0, 0, 0, 8'd2, 3'b100, 0, 3'b000);
    add(1, 1, 1, 1, 0, 0, 0, 8'd3, 3'b000, 0, 3'b000);
    // dead_cyc change mid-interval ignored; request rising on expiry is granted
    add(2, 0, 1, 0, 0, 0, 0, 8'd0, 3'b000, 0, 3'b000);
    add(1, 0, 1, 1, 0, 0, 0, 8'd0, 3'b100, 0, 3'b000);

    foreach (vecs[i]) begin
      rst_in = vecs[i].rst; en = vecs[i].en; fault_clr = vecs[i].clr;
      pwm_t = vecs[i].t; pwm_a = vecs[i].a; pwm_b = vecs[i].b; dead_cyc = vecs[i].dead;
      step();
      chk($sformatf("vec%0d_gates", i), {gate_t, gate_a, gate_b}, vecs[i].eg);
      chk($sformatf("vec%0d_fault", i), fault, vecs[i].ef);
      chk($sformatf("vec%0d_fault_src", i), fault_src, vecs[i].es);
    end

    rst_in = 1'b1; en = 1'b1; fault_clr = 1'b0; dead_cyc = 8'd3;
    pwm_t = 1'b0; pwm_a = 1'b0; pwm_b = 1'b0;
    step();
    for (int i = 0; i < 4000; i++) begin
      rst_in    = ($urandom_range(0, 599) == 0);
      fault_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) pwm_t = ~pwm_t;
      if ($urandom_range(0, 5) == 0) pwm_a = ~pwm_a;
      if ($urandom_range(0, 5) == 0) pwm_b = ~pwm_b;
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0)
        dead_cyc = ($urandom_range(0, 9) == 0) ? DT_DEF : 8'($urandom_range(0, 5));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
